// File: rtl/header.sv
// Shared definitions for the PC sequencer: operation encodings and default sizes.
package header;

    typedef enum logic [2:0] {
        PC_INC  = 3'd0,
        PC_JMP  = 3'd1,
        PC_BRR  = 3'd2,
        PC_CALL = 3'd3,
        PC_RET  = 3'd4
    } pc_op_t;

    localparam int unsigned DEFAULT_ADDR_W      = 6;
    localparam int unsigned DEFAULT_STACK_DEPTH = 4;

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses. Reset empties the stack; entry contents are left as-is.
module return_stack
    import header::*;
#(
    parameter int unsigned ADDR_W      = DEFAULT_ADDR_W,
    parameter int unsigned STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  logic                             pop,
    input  logic [ADDR_W-1:0]                wdata,
    output logic [ADDR_W-1:0]                top,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
    output logic                             full,
    output logic                             empty
);

    localparam int unsigned DW = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IW = $clog2(STACK_DEPTH);

    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [IW-1:0]     wr_idx;
    logic [IW-1:0]     rd_idx;

    // While not full, depth fits in IW bits and names the next free slot.
    assign wr_idx = depth[IW-1:0];
    assign rd_idx = wr_idx - 1'b1;

    assign full  = (depth == DW'(STACK_DEPTH));
    assign empty = (depth == '0);

    // Top-of-stack read; forced to zero when empty so the index is never stale.
    always_comb begin
        top = '0;
        if (!empty) begin
            top = mem[rd_idx];
        end
    end

    // Entry storage: written on a push, never reset.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= wdata;
        end
    end

    // Occupancy count: the only stack state cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth <= '0;
        end else if (push && !full) begin
            depth <= depth + 1'b1;
        end else if (pop && !empty) begin
            depth <= depth - 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: inc/jump/branch/call/return with a sticky stack fault.
module pc_sequencer
    import header::*;
#(
    parameter int unsigned       ADDR_W      = DEFAULT_ADDR_W,
    parameter int unsigned       STACK_DEPTH = DEFAULT_STACK_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic [2:0]                       op,
    input  logic [ADDR_W-1:0]                target,
    input  logic [ADDR_W-1:0]                offset,
    output logic [ADDR_W-1:0]                pc,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
    output logic                             fault
);

    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] stk_top;
    logic              fault_next;
    logic              push;
    logic              pop;
    logic              stk_full;
    logic              stk_empty;

    assign pc_inc = pc + 1'b1;

    return_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (pc_inc),
        .top   (stk_top),
        .depth (depth),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // Next-PC mux and push/pop/fault decision; nothing moves unless enabled and not halted.
    always_comb begin
        pc_next    = pc;
        fault_next = fault;
        push       = 1'b0;
        pop        = 1'b0;
        if (enable && !fault) begin
            case (pc_op_t'(op))
                PC_JMP: pc_next = target;
                PC_BRR: pc_next = pc + offset;
                PC_CALL: begin
                    if (stk_full) begin
                        fault_next = 1'b1;
                    end else begin
                        push    = 1'b1;
                        pc_next = target;
                    end
                end
                PC_RET: begin
                    if (stk_empty) begin
                        fault_next = 1'b1;
                    end else begin
                        pop     = 1'b1;
                        pc_next = stk_top;
                    end
                end
                default: pc_next = pc_inc;
            endcase
        end
    end

    // PC and sticky fault registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= RESET_PC;
            fault <= 1'b0;
        end else begin
            pc    <= pc_next;
            fault <= fault_next;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a queue-based reference model predicts each edge.
module tb_pc_sequencer;
    import header::*;

    localparam int AW = 6;
    localparam int SD = 4;
    localparam int MOD = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [2:0]    op = '0;
    logic [AW-1:0] target = '0;
    logic [AW-1:0] offset = '0;
    logic [AW-1:0] pc;
    logic [2:0]    depth;
    logic          fault;

    pc_sequencer #(
        .ADDR_W      (AW),
        .STACK_DEPTH (SD),
        .RESET_PC    ('0)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .op     (op),
        .target (target),
        .offset (offset),
        .pc     (pc),
        .depth  (depth),
        .fault  (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    pc;
        int    depth;
        int    fault;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state
    int   m_pc = 0;
    int   m_stk[$];
    int   m_fault = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_stk.delete();
        m_fault = 0;
    endtask

    // Apply one operation to the model in terms of the architectural rules.
    task automatic model_step(input int en, input int o, input int tg, input int of);
        if (en != 0 && m_fault == 0) begin
            case (o)
                1: m_pc = tg;
                2: m_pc = (m_pc + of) % MOD;
                3: begin
                    if (m_stk.size() == SD) m_fault = 1;
                    else begin
                        m_stk.push_back((m_pc + 1) % MOD);
                        m_pc = tg;
                    end
                end
                4: begin
                    if (m_stk.size() == 0) m_fault = 1;
                    else m_pc = m_stk.pop_back();
                end
                default: m_pc = (m_pc + 1) % MOD;
            endcase
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and queue the prediction.
    task automatic step(input int en, input int o, input int tg, input int of, input string tag);
        exp_t e;
        @(negedge clk);
        enable = (en != 0);
        op     = 3'(o);
        target = AW'(tg);
        offset = AW'(of);
        model_step(en, o, tg, of);
        e.pc = m_pc;
        e.depth = m_stk.size();
        e.fault = m_fault;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Assert reset between edges and check it takes effect without a clock.
    task automatic async_rst(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b1;
        enable = 1'b0;
        #1;
        model_reset();
        chk({tag, "_pc"}, int'(pc), m_pc);
        chk({tag, "_depth"}, int'(depth), 0);
        chk({tag, "_fault"}, int'(fault), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: every rising edge with a pending prediction is compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.tag, "_pc"}, int'(pc), e.pc);
                chk({e.tag, "_depth"}, int'(depth), e.depth);
                chk({e.tag, "_fault"}, int'(fault), e.fault);
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_pc", int'(pc), 0);
        chk("reset_depth", int'(depth), 0);
        chk("reset_fault", int'(fault), 0);

        // Sequential increment and enable hold
        repeat (3) step(1, PC_INC, 0, 0, "inc");
        step(0, PC_JMP, 7'h2A, 0, "hold");
        step(0, PC_CALL, 7'h15, 0, "hold");

        // Wrap-around and negative branch
        step(1, PC_JMP, 'h3F, 0, "jmp3f");
        step(1, PC_INC, 0, 0, "wrap_inc");
        step(1, PC_JMP, 'h05, 0, "jmp05");
        step(1, PC_BRR, 0, 'h3E, "brr_neg");
        step(1, PC_BRR, 0, 'h3F, "brr_m1");

        // Single call/return
        step(1, PC_JMP, 'h10, 0, "jmp10");
        step(1, PC_CALL, 'h20, 0, "call");
        step(1, PC_RET, 0, 0, "ret");

        // Call at all-ones pushes zero
        step(1, PC_JMP, 'h3F, 0, "jmp3f_b");
        step(1, PC_CALL, 'h04, 0, "call_wrap");
        step(1, PC_RET, 0, 0, "ret_wrap");

        // Nested calls to overflow, then halted
        step(1, PC_JMP, 'h01, 0, "jmp01");
        step(1, PC_CALL, 'h08, 0, "nest1");
        step(1, PC_CALL, 'h10, 0, "nest2");
        step(1, PC_CALL, 'h18, 0, "nest3");
        step(1, PC_CALL, 'h20, 0, "nest4");
        step(1, PC_CALL, 'h30, 0, "overflow");
        step(1, PC_INC, 0, 0, "halt_inc");
        step(1, PC_RET, 0, 0, "halt_ret");
        async_rst("rst_ovf");

        // Underflow after reset
        step(1, PC_RET, 0, 0, "underflow");
        step(1, PC_JMP, 'h11, 0, "halt_jmp");
        async_rst("rst_unf");

        // Reset mid-stack empties it
        step(1, PC_CALL, 'h0A, 0, "c1");
        step(1, PC_CALL, 'h0B, 0, "c2");
        async_rst("rst_mid");
        step(1, PC_RET, 0, 0, "ret_after_rst");
        async_rst("rst_end");

        // Randomized traffic including undefined encodings
        for (int i = 0; i < 400; i++) begin
            if (m_fault != 0 && $urandom_range(0, 3) == 0) begin
                async_rst("rst_rand");
            end else begin
                step(($urandom_range(0, 4) != 0) ? 1 : 0,
                     int'($urandom_range(0, 7)),
                     int'($urandom_range(0, MOD - 1)),
                     int'($urandom_range(0, MOD - 1)),
                     "rand");
            end
        end

        @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
